// File: rtl/riscv_reg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_reg_pkg
// Purpose  : Shared types, ABI name table and character helpers for the
//            register-name parser.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_reg_pkg;

    localparam int c_name_chars = 4;

    typedef logic [4:0]                   reg_num_t;
    typedef logic [c_name_chars-1:0][7:0] reg_name_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } parse_state_t;

    localparam logic [7:0] c_chr_space  = 8'h20;
    localparam logic [7:0] c_chr_tab    = 8'h09;
    localparam logic [7:0] c_chr_comma  = 8'h2c;
    localparam logic [7:0] c_chr_lparen = 8'h28;
    localparam logic [7:0] c_chr_rparen = 8'h29;
    localparam logic [7:0] c_chr_lf     = 8'h0a;
    localparam logic [7:0] c_chr_cr     = 8'h0d;
    localparam logic [7:0] c_chr_nul    = 8'h00;

    // Index in this table is the register number; names are left-aligned, NUL-padded.
    localparam reg_name_t c_abi_names [32] = '{
        "zero",        {"ra", 16'h0}, {"sp", 16'h0}, {"gp", 16'h0},
        {"tp", 16'h0}, {"t0", 16'h0}, {"t1", 16'h0}, {"t2", 16'h0},
        {"s0", 16'h0}, {"s1", 16'h0}, {"a0", 16'h0}, {"a1", 16'h0},
        {"a2", 16'h0}, {"a3", 16'h0}, {"a4", 16'h0}, {"a5", 16'h0},
        {"a6", 16'h0}, {"a7", 16'h0}, {"s2", 16'h0}, {"s3", 16'h0},
        {"s4", 16'h0}, {"s5", 16'h0}, {"s6", 16'h0}, {"s7", 16'h0},
        {"s8", 16'h0}, {"s9", 16'h0}, {"s10", 8'h0}, {"s11", 8'h0},
        {"t3", 16'h0}, {"t4", 16'h0}, {"t5", 16'h0}, {"t6", 16'h0}
    };
    localparam reg_name_t c_name_fp = {"fp", 16'h0};

    function automatic logic is_delim(input logic [7:0] c);
        return (c == c_chr_space)  || (c == c_chr_tab)    || (c == c_chr_comma) ||
               (c == c_chr_lparen) || (c == c_chr_rparen) || (c == c_chr_lf)    ||
               (c == c_chr_cr)     || (c == c_chr_nul);
    endfunction

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic logic [7:0] to_lower(input logic [7:0] c);
        return ((c >= 8'h41) && (c <= 8'h5a)) ? (c | 8'h20) : c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_name_lookup.sv
`default_nettype none
// ============================================================================
// Module   : reg_name_lookup
// Purpose  : Combinational map from a captured token to a register number.
//            Define REG_PARSER_XNAME_EN to also accept numeric names x0..x31.
// Revision : 1.0 - initial release
// ============================================================================
module reg_name_lookup
    import riscv_reg_pkg::*;
(
    input  reg_name_t i_token,
    input  logic      i_overflow,
    output reg_num_t  o_reg_number,
    output logic      o_error
);

    logic     w_hit;
    reg_num_t w_num;
`ifdef REG_PARSER_XNAME_EN
    logic [7:0] w_d1;
    logic [7:0] w_d2;
    logic [6:0] w_val;
`endif

    always_comb begin
        w_hit = 1'b0;
        w_num = '0;
        for (int i = 0; i < 32; i++) begin
            if (i_token == c_abi_names[i]) begin
                w_hit = 1'b1;
                w_num = reg_num_t'(i);
            end
        end
        if (i_token == c_name_fp) begin
            w_hit = 1'b1;
            w_num = 5'd8;
        end
`ifdef REG_PARSER_XNAME_EN
        w_d1  = i_token[c_name_chars-2];
        w_d2  = i_token[c_name_chars-3];
        w_val = ({3'b000, w_d1[3:0]} * 7'd10) + {3'b000, w_d2[3:0]};
        // Single digit allows "x0"; two digits forbid a leading zero.
        if ((i_token[c_name_chars-1] == 8'h78) && (i_token[0] == 8'h00)) begin
            if (is_digit(w_d1) && (w_d2 == 8'h00)) begin
                w_hit = 1'b1;
                w_num = {1'b0, w_d1[3:0]};
            end else if (is_digit(w_d1) && (w_d1 != 8'h30) && is_digit(w_d2) &&
                         (w_val <= 7'd31)) begin
                w_hit = 1'b1;
                w_num = w_val[4:0];
            end
        end
`endif
        o_error      = i_overflow || !w_hit;
        o_reg_number = o_error ? '0 : w_num;
    end

endmodule
`default_nettype wire

// File: rtl/reg_name_parser.sv
`default_nettype none
// ============================================================================
// Module   : reg_name_parser
// Purpose  : Streaming ASCII register-name parser with valid/ready in and out.
//            Numeric xN names are enabled by defining REG_PARSER_XNAME_EN.
// Revision : 1.0 - initial release
// ============================================================================
module reg_name_parser
    import riscv_reg_pkg::*;
#(
    parameter int REGISTER_NAME_WIDTH = 4,
    parameter int REGISTER_WIDTH      = 5
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [7:0]                       in_char,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [REGISTER_WIDTH-1:0]        out_reg_number,
    output logic                             out_error,
    output logic [REGISTER_NAME_WIDTH*8-1:0] out_name
);

    localparam int                 c_cnt_w   = $clog2(REGISTER_NAME_WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(REGISTER_NAME_WIDTH);

    parse_state_t                            r_state_q, w_state_d;
    logic [REGISTER_NAME_WIDTH-1:0][7:0]     r_buf_q, w_buf_d;
    logic [c_cnt_w-1:0]                      r_cnt_q, w_cnt_d;
    logic                                    r_ovf_q, w_ovf_d;
    logic                                    r_valid_q, w_valid_d;
    logic                                    r_err_q, w_err_d;
    logic [REGISTER_WIDTH-1:0]               r_reg_q, w_reg_d;
    logic [REGISTER_NAME_WIDTH-1:0][7:0]     r_name_q, w_name_d;

    logic       w_xfer;
    logic       w_start;
    logic [7:0] w_char;
    logic       w_is_delim;
    reg_num_t   w_lut_num;
    logic       w_lut_err;

    assign in_ready   = (r_state_q != EMIT) || out_ready;
    assign w_xfer     = in_valid && in_ready;
    assign w_char     = to_lower(in_char);
    assign w_is_delim = is_delim(in_char);

    reg_name_lookup u_lookup (
        .i_token      (r_buf_q),
        .i_overflow   (r_ovf_q),
        .o_reg_number (w_lut_num),
        .o_error      (w_lut_err)
    );

    always_comb begin
        w_state_d = r_state_q;
        w_buf_d   = r_buf_q;
        w_cnt_d   = r_cnt_q;
        w_ovf_d   = r_ovf_q;
        w_valid_d = r_valid_q;
        w_err_d   = r_err_q;
        w_reg_d   = r_reg_q;
        w_name_d  = r_name_q;
        w_start   = (r_state_q == IDLE);

        // Handshake frees the output; a character in the same cycle starts afresh.
        if ((r_state_q == EMIT) && out_ready) begin
            w_valid_d = 1'b0;
            w_state_d = IDLE;
            w_start   = 1'b1;
        end

        if (w_xfer) begin
            if (w_start) begin
                if (!w_is_delim) begin
                    w_buf_d                        = '0;
                    w_buf_d[REGISTER_NAME_WIDTH-1] = w_char;
                    w_cnt_d                        = c_cnt_w'(1);
                    w_ovf_d                        = 1'b0;
                    w_state_d                      = ACCUM;
                end
            end else if (!w_is_delim) begin
                if (r_cnt_q < c_cnt_max) begin
                    for (int p = 0; p < REGISTER_NAME_WIDTH; p++) begin
                        if (r_cnt_q == c_cnt_w'(p)) begin
                            w_buf_d[REGISTER_NAME_WIDTH-1-p] = w_char;
                        end
                    end
                    w_cnt_d = r_cnt_q + c_cnt_w'(1);
                end else begin
                    w_ovf_d = 1'b1;
                end
            end else begin
                w_valid_d = 1'b1;
                w_err_d   = w_lut_err;
                w_reg_d   = REGISTER_WIDTH'(w_lut_num);
                w_name_d  = r_buf_q;
                w_state_d = EMIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= IDLE;
            r_buf_q   <= '0;
            r_cnt_q   <= '0;
            r_ovf_q   <= 1'b0;
            r_valid_q <= 1'b0;
            r_err_q   <= 1'b0;
            r_reg_q   <= '0;
            r_name_q  <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_buf_q   <= w_buf_d;
            r_cnt_q   <= w_cnt_d;
            r_ovf_q   <= w_ovf_d;
            r_valid_q <= w_valid_d;
            r_err_q   <= w_err_d;
            r_reg_q   <= w_reg_d;
            r_name_q  <= w_name_d;
        end
    end

    assign out_valid      = r_valid_q;
    assign out_error      = r_err_q;
    assign out_reg_number = r_reg_q;
    assign out_name       = r_name_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_name_parser.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_name_parser
// Purpose  : Directed self-checking bench for reg_name_parser.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_reg_name_parser;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_char;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  out_reg_number;
    logic        out_error;
    logic [31:0] out_name;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic [4:0]  num;
        logic        err;
        logic [31:0] name;
    } res_t;
    res_t results[$];

    always #5 clk = ~clk;

    reg_name_parser dut (
        .clk            (clk),
        .reset          (reset),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_char        (in_char),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_reg_number (out_reg_number),
        .out_error      (out_error),
        .out_name       (out_name)
    );

    always @(posedge clk) begin
        if (!reset && out_valid && out_ready)
            results.push_back({out_reg_number, out_error, out_name});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] c);
        int guard;
        guard = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_char  = c;
        #1;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            #1;
            guard++;
        end
        if (!in_ready) check("send_timeout", {31'b0, in_ready}, 32'd1);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic drain();
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic expect_res(input string tag, input logic [4:0] num,
                              input logic err, input logic [31:0] name);
        res_t r;
        if (results.size() == 0) begin
            check({tag, "_present"}, 32'd0, 32'd1);
        end else begin
            r = results.pop_front();
            check({tag, "_num"},  {27'b0, r.num}, {27'b0, num});
            check({tag, "_err"},  {31'b0, r.err}, {31'b0, err});
            check({tag, "_name"}, r.name, name);
        end
    endtask

    task automatic expect_none(input string tag);
        check({tag, "_extra"}, results.size(), 32'd0);
        results.delete();
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_char   = 8'h00;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_error", {31'b0, out_error}, 32'd0);
        check("rst_num",   {27'b0, out_reg_number}, 32'd0);
        check("rst_name",  out_name, 32'd0);
        check("rst_ready", {31'b0, in_ready}, 32'd1);
        reset = 1'b0;

        // Single token with exact one-cycle latency
        send("s"); send("p"); send(",");
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("sp_lat_valid", {31'b0, out_valid}, 32'd1);
        check("sp_lat_num",   {27'b0, out_reg_number}, 32'd2);
        check("sp_lat_err",   {31'b0, out_error}, 32'd0);
        check("sp_lat_name",  out_name, 32'h7370_0000);
        drain();
        expect_res("sp", 5'd2, 1'b0, 32'h7370_0000);
        expect_none("sp");

        // Leading delimiters, case folding, a7 vs s7, three-char name
        send_str("  A7 s11)");
        drain();
        expect_res("a7",  5'd17, 1'b0, 32'h6137_0000);
        expect_res("s11", 5'd27, 1'b0, 32'h7331_3100);
        expect_none("a7s11");

        // Back-pressure: result held while the next char waits
        out_ready = 1'b0;
        send_str("ra,");
        @(negedge clk);
        in_valid = 1'b1;
        in_char  = "t";
        #1;
        for (int k = 0; k < 5; k++) begin
            check("hold_valid", {31'b0, out_valid}, 32'd1);
            check("hold_num",   {27'b0, out_reg_number}, 32'd1);
            check("hold_ready", {31'b0, in_ready}, 32'd0);
            @(negedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1;
        check("release_ready", {31'b0, in_ready}, 32'd1);
        send("6"); send(",");
        drain();
        expect_res("ra", 5'd1,  1'b0, 32'h7261_0000);
        expect_res("t6", 5'd31, 1'b0, 32'h7436_0000);
        expect_none("rat6");

        // Overflow and unknown tokens
        send_str("zeros foo zero ");
        drain();
        expect_res("zeros", 5'd0, 1'b1, 32'h7a65_726f);
        expect_res("foo",   5'd0, 1'b1, 32'h666f_6f00);
        expect_res("zero",  5'd0, 1'b0, 32'h7a65_726f);
        expect_none("errs");

        // Aliases and assorted names
        send_str("fp\ts0 t2(a0\nTP\r");
        drain();
        expect_res("fp", 5'd8,  1'b0, 32'h6670_0000);
        expect_res("s0", 5'd8,  1'b0, 32'h7330_0000);
        expect_res("t2", 5'd7,  1'b0, 32'h7432_0000);
        expect_res("a0", 5'd10, 1'b0, 32'h6130_0000);
        expect_res("tp", 5'd4,  1'b0, 32'h7470_0000);
        expect_none("alias");

        // Reset mid-token discards the partial token
        send_str("s1");
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        #1;
        check("midrst_valid", {31'b0, out_valid}, 32'd0);
        reset = 1'b0;
        send_str("gp ");
        drain();
        expect_res("gp", 5'd3, 1'b0, 32'h6770_0000);
        expect_none("gp");

`ifdef REG_PARSER_XNAME_EN
        send_str("x31 x32 x0 x01 x ");
        drain();
        expect_res("x31", 5'd31, 1'b0, 32'h7833_3100);
        expect_res("x32", 5'd0,  1'b1, 32'h7833_3200);
        expect_res("x0",  5'd0,  1'b0, 32'h7830_0000);
        expect_res("x01", 5'd0,  1'b1, 32'h7830_3100);
        expect_res("x",   5'd0,  1'b1, 32'h7800_0000);
        expect_none("xname");
`else
        send_str("x31 x0 ");
        drain();
        expect_res("x31", 5'd0, 1'b1, 32'h7833_3100);
        expect_res("x0",  5'd0, 1'b1, 32'h7830_0000);
        expect_none("xname");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
